// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, majority-voted bit decode with break handling.
// Presents each good byte on RX_data with a one-cycle byte_done strobe.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] RX_data,
    output logic       byte_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned MID    = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta, rxs, rxs_prev;
    logic [DIV_W-1:0]    div_cnt;
    logic [SCNT_W-1:0]   scnt;
    logic                s_lo, s_mid;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          rx_data_d;
    logic                byte_done_d, frame_err_d;
    logic                start_c, tick_c, resolve_c, vote_c;

    // Two-flop synchronizer plus previous value for falling-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign start_c   = (state_q == S_IDLE) && rxs_prev && !rxs;
    assign tick_c    = (div_cnt == DIV_W'(DIV - 1));
    assign resolve_c = tick_c && (scnt == SCNT_W'(MID + 1));
    assign vote_c    = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

    // Tick divider and sample counter, phase-aligned to the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            scnt    <= '0;
        end else if (start_c) begin
            div_cnt <= '0;
            scnt    <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
            scnt    <= (scnt == SCNT_W'(OVERSAMPLE - 1)) ? '0 : scnt + SCNT_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // First two of the three voting samples; the third is live rxs at resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
        end else if (tick_c) begin
            if (scnt == SCNT_W'(MID - 1)) s_lo  <= rxs;
            if (scnt == SCNT_W'(MID))     s_mid <= rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            RX_data   <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            RX_data   <= rx_data_d;
            byte_done <= byte_done_d;
            frame_err <= frame_err_d;
            busy      <= (state_q != S_IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        rx_data_d   = RX_data;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_c) state_d = S_START;
            end
            S_START: begin
                if (resolve_c) begin
                    if (!vote_c) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (resolve_c) begin
                    shift_d = {vote_c, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (resolve_c) begin
                    if (vote_c) begin
                        rx_data_d   = shift_q;
                        byte_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            // Held-low line must return high before a new start is accepted
            S_BREAK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected results,
// a negedge monitor pops and compares on every byte_done / frame_err strobe.
module tb_uart_rx;

    localparam int CLK_F    = 50_000_000;
    localparam int DIV      = 27;            // 50e6 / (115200*16) truncated
    localparam int BIT_CYC  = 432;           // 16 * DIV
    localparam int FAST_CYC = 424;           // transmitter ~2% fast
    localparam int MID_OFS  = 243;           // DIV * (M+1): centre sample offset

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       byte_done;
    logic       frame_err;
    logic       busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx #(
        .CLK_FREQ  (CLK_F),
        .BAUD_RATE (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .RX_data  (rx_data),
        .byte_done(byte_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input bit is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endfunction

    // Monitor: strobe contents, strobe width/exclusivity, busy drop after byte_done
    bit   done_prev = 1'b0;
    exp_t got_e;
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                check("busy_after_done", busy, 0);
                check("done_width", byte_done, 0);
            end
            if (byte_done || frame_err) begin
                check("strobe_overlap", byte_done & frame_err, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: byte_done=%0b frame_err=%0b RX_data=0x%0h, expected no strobe",
                             byte_done, frame_err, rx_data);
                end else begin
                    got_e = exp_q.pop_front();
                    check("strobe_kind_err", frame_err, got_e.is_err);
                    check("rx_data", rx_data, got_e.data);
                end
            end
            done_prev = byte_done;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // One 8N1 frame; optional centre-sample spikes and async reset at cycle rst_at
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bc,
                              input bit spikes, input int rst_at);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int c = 0; c < 10 * bc; c++) begin
            logic v;
            v = bits[c / bc];
            if (spikes && (c % BIT_CYC) == MID_OFS) v = ~v;
            @(negedge clk);
            rx = v;
            if (c == rst_at) begin
                #2;
                rst = 1'b1;
                #1;
                check("rst_rx_data", rx_data, 8'h00);
                check("rst_byte_done", byte_done, 0);
                check("rst_frame_err", frame_err, 0);
                check("rst_busy", busy, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_byte_done", byte_done, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(20);

        // Single byte
        push(1'b0, 8'h0F);
        send_frame(8'h0F, 1'b1, BIT_CYC, 1'b0, -1);
        idle(100);

        // Back-to-back stream, no idle gap
        push(1'b0, 8'hFF);
        push(1'b0, 8'h00);
        push(1'b0, 8'hA5);
        push(1'b0, 8'h5A);
        send_frame(8'hFF, 1'b1, BIT_CYC, 1'b0, -1);
        send_frame(8'h00, 1'b1, BIT_CYC, 1'b0, -1);
        send_frame(8'hA5, 1'b1, BIT_CYC, 1'b0, -1);
        send_frame(8'h5A, 1'b1, BIT_CYC, 1'b0, -1);
        idle(100);

        // Glitch: 3-tick low pulse on idle line
        for (int c = 0; c < BIT_CYC + 10; c++) begin
            @(negedge clk);
            rx = (c < 3 * DIV) ? 1'b0 : 1'b1;
            if (c == 40) check("glitch_busy_high", busy, 1);
        end
        check("glitch_busy_low", busy, 0);
        check("glitch_rx_data", rx_data, 8'h5A);

        // Framing error then 20-bit break
        push(1'b1, 8'h5A);
        send_frame(8'h3C, 1'b0, BIT_CYC, 1'b0, -1);
        for (int c = 0; c < 20 * BIT_CYC; c++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        check("break_busy", busy, 1);
        idle(BIT_CYC);
        check("break_rx_data", rx_data, 8'h5A);
        check("break_busy_low", busy, 0);
        push(1'b0, 8'h81);
        send_frame(8'h81, 1'b1, BIT_CYC, 1'b0, -1);
        idle(100);

        // Noise spikes at centre samples with a fast transmitter
        push(1'b0, 8'hC3);
        send_frame(8'hC3, 1'b1, FAST_CYC, 1'b1, -1);
        idle(200);

        // Reset during data bit 4 of 0x55, held through the rest of the frame
        send_frame(8'h55, 1'b1, BIT_CYC, 1'b0, 5 * BIT_CYC + 200);
        idle(50);
        rst = 1'b0;
        idle(100);
        check("post_rst_rx_data", rx_data, 8'h00);
        push(1'b0, 8'h99);
        send_frame(8'h99, 1'b1, BIT_CYC, 1'b0, -1);
        idle(200);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
